// File: rtl/mmio_mailbox_if.sv
// Core data-bus bundle for the MMIO mailbox.
// The core drives requests, the mailbox returns one-cycle responses.
interface mmio_mailbox_if;
   logic [31:0] core__d_addr;
   logic [31:0] core__d_wdata;
   logic        core__d_ren;
   logic [3:0]  core__d_wen;
   logic [10:0] core__d_req_tag;
   logic        d__core_accept;
   logic        d__core_val;
   logic        d__core_error;
   logic [31:0] d__core_rdata;
   logic [10:0] d__core_resp_tag;

   modport master (
      output core__d_addr, core__d_wdata, core__d_ren,
      output core__d_wen, core__d_req_tag,
      input  d__core_accept, d__core_val, d__core_error,
      input  d__core_rdata, d__core_resp_tag
   );

   modport slave (
      input  core__d_addr, core__d_wdata, core__d_ren,
      input  core__d_wen, core__d_req_tag,
      output d__core_accept, d__core_val, d__core_error,
      output d__core_rdata, d__core_resp_tag
   );
endinterface

// File: rtl/mmio_mailbox.sv
// Core/host byte mailbox: TX and RX FIFOs, status, scratch, control.
// Define MMIO_MAILBOX_IRQ_EN to drive a registered interrupt.
module mmio_mailbox #(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   mmio_mailbox_if.slave core,
   input  logic         we,
   input  logic [3:0]   addr,
   input  logic [7:0]   wdata,
   output logic [7:0]   rdata,
   output logic         intr
);
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;
   localparam cnt_t FULL = cnt_t'(DEPTH);

   logic [7:0] tx_mem_q [DEPTH];
   logic [7:0] rx_mem_q [DEPTH];
   ptr_t  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   ptr_t  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   cnt_t  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic  tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
   logic [31:0] scr_q, scr_d;
   logic        val_q, val_d, err_q, err_d;
   logic [31:0] rd_q, rd_d;
   logic [10:0] tag_q, tag_d;

   logic        req, is_wr, mis, wr_ok, rd_ok, clr;
   logic [1:0]  sel;
   logic [3:0]  wen;
   logic [31:0] wd, status;
   logic        tx_push, tx_pop, tx_acc, tx_drop;
   logic        rx_push, rx_pop, rx_acc, rx_drop;
   logic        tx_full, tx_empty, rx_full, rx_ne;
   logic        unused_addr;

   assign wen   = core.core__d_wen;
   assign wd    = core.core__d_wdata;
   assign sel   = core.core__d_addr[3:2];
   assign mis   = core.core__d_addr[1:0] != 2'b00;
   assign is_wr = |wen;
   assign req   = core.core__d_ren | is_wr;
   assign wr_ok = req & ~mis & is_wr;
   assign rd_ok = req & ~mis & ~is_wr;
   assign clr   = wr_ok & (sel == 2'd3) & wen[0] & wd[0];
   assign unused_addr = ^core.core__d_addr[31:4];

   assign tx_full  = tx_cnt_q == FULL;
   assign tx_empty = tx_cnt_q == '0;
   assign rx_full  = rx_cnt_q == FULL;
   assign rx_ne    = rx_cnt_q != '0;
   assign status   = {26'b0, rx_ovf_q, tx_ovf_q,
                      rx_full, tx_empty, tx_full, rx_ne};

   // A pop frees a slot in the same cycle, so push-on-full is legal with it
   assign tx_push = wr_ok & (sel == 2'd0) & wen[0];
   assign tx_pop  = we & (addr == 4'd1) & ~tx_empty;
   assign tx_acc  = tx_push & (~tx_full | tx_pop);
   assign tx_drop = tx_push & ~tx_acc;

   assign rx_push = we & (addr == 4'd0) & ~clr;
   assign rx_pop  = rd_ok & (sel == 2'd0) & rx_ne;
   assign rx_acc  = rx_push & (~rx_full | rx_pop);
   assign rx_drop = rx_push & ~rx_acc;

   always_comb begin
      tx_wp_d  = tx_wp_q;
      tx_rp_d  = tx_rp_q;
      tx_cnt_d = tx_cnt_q;
      tx_ovf_d = tx_ovf_q;
      rx_wp_d  = rx_wp_q;
      rx_rp_d  = rx_rp_q;
      rx_cnt_d = rx_cnt_q;
      rx_ovf_d = rx_ovf_q;
      if (clr) begin
         tx_wp_d  = '0;
         tx_rp_d  = '0;
         tx_cnt_d = '0;
         tx_ovf_d = 1'b0;
         rx_wp_d  = '0;
         rx_rp_d  = '0;
         rx_cnt_d = '0;
         rx_ovf_d = 1'b0;
      end else begin
         if (tx_acc) tx_wp_d = tx_wp_q + 1'b1;
         if (tx_pop) tx_rp_d = tx_rp_q + 1'b1;
         tx_cnt_d = tx_cnt_q + cnt_t'(tx_acc) - cnt_t'(tx_pop);
         if (tx_drop) tx_ovf_d = 1'b1;
         if (rx_acc) rx_wp_d = rx_wp_q + 1'b1;
         if (rx_pop) rx_rp_d = rx_rp_q + 1'b1;
         rx_cnt_d = rx_cnt_q + cnt_t'(rx_acc) - cnt_t'(rx_pop);
         if (rx_drop) rx_ovf_d = 1'b1;
      end
   end

   always_comb begin
      scr_d = scr_q;
      if (wr_ok && sel == 2'd2) begin
         for (int i = 0; i < 4; i++)
            if (wen[i]) scr_d[8*i +: 8] = wd[8*i +: 8];
      end
   end

   always_comb begin
      val_d = req;
      err_d = req & mis;
      tag_d = req ? core.core__d_req_tag : tag_q;
      rd_d  = '0;
      if (rd_ok) begin
         unique case (sel)
            2'd0: rd_d = rx_ne ? {24'b0, rx_mem_q[rx_rp_q]} : '0;
            2'd1: rd_d = status;
            2'd2: rd_d = scr_q;
            2'd3: rd_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         tx_ovf_q <= 1'b0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
         rx_ovf_q <= 1'b0;
         scr_q    <= '0;
         val_q    <= 1'b0;
         err_q    <= 1'b0;
         rd_q     <= '0;
         tag_q    <= '0;
      end else begin
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         tx_cnt_q <= tx_cnt_d;
         tx_ovf_q <= tx_ovf_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         rx_cnt_q <= rx_cnt_d;
         rx_ovf_q <= rx_ovf_d;
         scr_q    <= scr_d;
         val_q    <= val_d;
         err_q    <= err_d;
         rd_q     <= rd_d;
         tag_q    <= tag_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && tx_acc) tx_mem_q[tx_wp_q] <= wd[7:0];
      if (!rst && rx_acc) rx_mem_q[rx_wp_q] <= wdata;
   end

   assign core.d__core_accept    = ~rst;
   assign core.d__core_val       = val_q;
   assign core.d__core_error     = err_q;
   assign core.d__core_rdata     = rd_q;
   assign core.d__core_resp_tag  = tag_q;

   always_comb begin
      rdata = 8'h00;
      unique case (addr)
         4'd0:    rdata = tx_empty ? 8'h00 : tx_mem_q[tx_rp_q];
         4'd2:    rdata = status[7:0];
         4'd4:    rdata = scr_q[7:0];
         4'd5:    rdata = scr_q[15:8];
         4'd6:    rdata = scr_q[23:16];
         4'd7:    rdata = scr_q[31:24];
         default: rdata = 8'h00;
      endcase
   end

`ifdef MMIO_MAILBOX_IRQ_EN
   logic intr_q;
   always_ff @(posedge clk) begin
      if (rst) intr_q <= 1'b0;
      else     intr_q <= rx_ne | tx_ovf_q | rx_ovf_q;
   end
   assign intr = intr_q;
`else
   assign intr = 1'b0;
`endif
endmodule

// File: doc/mmio_mailbox.md
MMIO_MAILBOX -- requirements
Module: mmio_mailbox

Interface
REQ-001 Parameter DEPTH, default 4: entries per byte FIFO; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 core__d_addr  input  32  core data address; only bits [3:2] (register select) and [1:0] (alignment check) are decoded.
REQ-005 core__d_wdata  input  32  core write data.
REQ-006 core__d_ren  input  1  core read request.
REQ-007 core__d_wen  input  4  core byte write strobes.
REQ-008 core__d_req_tag  input  11  request tag.
REQ-009 d__core_accept  output  1  request accepted.
REQ-010 d__core_val  output  1  response valid.
REQ-011 d__core_error  output  1  response error.
REQ-012 d__core_rdata  output  32  response read data.
REQ-013 d__core_resp_tag  output  11  response tag.
REQ-014 we  input  1  host write strobe.
REQ-015 addr  input  4  host register select.
REQ-016 wdata  input  8  host write data.
REQ-017 rdata  output  8  host read data, combinational from addr.
REQ-018 intr  output  1  interrupt to core.

Function
REQ-019 The block SHALL hold two FIFOs of DEPTH bytes each: TX (core pushes, host pops) and RX (host pushes, core pops).
REQ-020 d__core_accept SHALL be 1 whenever rst is low.
REQ-021 A request is core__d_ren or any core__d_wen bit set. For each request, exactly one cycle later: d__core_val=1, d__core_resp_tag = the captured tag. With no request, d__core_val=0 the next cycle.
REQ-022 If core__d_ren and core__d_wen are both active, the request SHALL be handled as a write only; its response rdata SHALL be 0.
REQ-023 A request with core__d_addr[1:0] != 0 SHALL cause no side effect and SHALL respond with error=1, rdata=0. All other responses SHALL have error=0.
REQ-024 Core register 0 (DATA), write: pushes wdata[7:0] into TX only if wen[0]=1.
REQ-025 Core register 0 (DATA), read: pops RX and returns {24'b0, byte}; if RX is empty it returns 0 and pops nothing.
REQ-026 Core register 1 (STATUS), read-only: bit0 rx_nonempty, bit1 tx_full, bit2 tx_empty, bit3 rx_full, bit4 tx_overflow, bit5 rx_overflow; other bits 0. Writes are ignored.
REQ-027 Core register 2 (SCRATCH): 32-bit read/write; each wen[i] updates byte lane i.
REQ-028 Core register 3 (CTRL), write with wen[0]=1 and wdata[0]=1: empties both FIFOs and clears both overflow flags. Reads of CTRL return 0.
REQ-029 Read data SHALL reflect state before the request cycle's update.
REQ-030 Host write, addr 0: pushes wdata into RX.
REQ-031 Host write, addr 1: pops TX (wdata ignored); no effect if TX is empty.
REQ-032 Host writes to any other addr SHALL be ignored.
REQ-033 Host rdata: addr 0 gives TX head byte (0 if empty); addr 2 gives STATUS[7:0]; addr 4..7 give SCRATCH byte 0..3; all other addr give 0.
REQ-034 A push to a full FIFO with no same-cycle pop SHALL be dropped and SHALL set that FIFO's sticky overflow flag.
REQ-035 Same-cycle push and pop on one FIFO: both SHALL succeed when the FIFO is nonempty, occupancy unchanged. When the FIFO is empty, only the push takes effect.
REQ-036 A CTRL clear in the same cycle as a host push SHALL take priority; the push is discarded.
REQ-037 Read/write pointers SHALL wrap modulo DEPTH; occupancy is tracked with a count from 0 to DEPTH.

Reset
REQ-038 While rst=1, the block SHALL hold: both FIFOs empty, overflow flags 0, SCRATCH=0, d__core_val=0, d__core_error=0, d__core_rdata=0, d__core_resp_tag=0, d__core_accept=0, intr=0.
REQ-039 Requests or host writes during reset SHALL be discarded with no response, including any in flight when rst rises.

Configuration
REQ-040 With macro MMIO_MAILBOX_IRQ_EN defined: intr SHALL be a register equal to rx_nonempty OR tx_overflow OR rx_overflow, one cycle after the state change.
REQ-041 Without MMIO_MAILBOX_IRQ_EN: intr SHALL be tied to 0, and no other behaviour changes.

Verification
REQ-042 Core writes 0x41, 0x42 to DATA (wen=4'h1) -> host reads addr 0 = 0x41; host write addr 1 -> host addr 0 = 0x42; one more pop -> STATUS tx_empty=1.
REQ-043 Host pushes 0x5A to RX -> core reads DATA, tag 0x123 -> next cycle val=1, rdata=0x5A, resp_tag=0x123; a second read returns 0.
REQ-044 Core pushes DEPTH+1 bytes to TX with no host pops -> STATUS tx_full=1, tx_overflow=1; CTRL write 1 -> STATUS reads 0x04.
REQ-045 TX full, core push and host pop in the same cycle -> occupancy stays DEPTH, overflow stays 0, new byte is last out.
REQ-046 SCRATCH write 0xDEADBEEF with wen=4'b0101 after reset -> SCRATCH read 0x00AD00EF; host addr 6 = 0xAD; misaligned read at offset 0x2 -> error=1.
REQ-047 With MMIO_MAILBOX_IRQ_EN: host push -> intr=1 one cycle later; core drains RX -> intr=0. Assert rst mid-transfer -> val=0 and FIFOs empty the next cycle.
